bpsk_symbol_mapper: RTL and testbench

BPSK_SYMBOL_MAPPER -- requirements
Module: bpsk_symbol_mapper

---
 rtl/bpsk_symbol_mapper_if.sv | 27 ++
 rtl/bpsk_symbol_mapper.sv | 223 ++++++++++++++++++++++
 tb/tb_bpsk_symbol_mapper.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_symbol_mapper_if.sv
// Byte-stream and sample-stream bundle for the BPSK symbol mapper.
// master: upstream byte source / sine generator / controller side.
// slave:  the mapper itself.
interface bpsk_symbol_mapper_if #(
    parameter int DATA_W = 12
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mod_en;
    logic              sample_strobe;
    logic [DATA_W-1:0] sine_in;
    logic              data_rdy;
    logic              bit_out;
    logic [DATA_W-1:0] mod_out;
    logic              mod_valid;

    modport master (
        output byte_in, byte_valid, mod_en, sample_strobe, sine_in,
        input  byte_ready, data_rdy, bit_out, mod_out, mod_valid
    );

    modport slave (
        input  byte_in, byte_valid, mod_en, sample_strobe, sine_in,
        output byte_ready, data_rdy, bit_out, mod_out, mod_valid
    );
endinterface

// File: rtl/bpsk_symbol_mapper.sv
// BPSK symbol mapper: buffers payload bytes in a 2-entry FIFO, shifts them
// out MSB first, and multiplies each carrier sample by +1/-1 per bit.
// Optional macro DBPSK_DIFF_EN: differential encoding of the symbol bit
// (bit_out = data bit XOR previous transmitted bit).
//
// state | meaning
// IDLE  | no bit in flight, waiting for a buffered byte
// SEND  | a byte is being shifted out, SPS accepted samples per bit
module bpsk_symbol_mapper #(
    parameter int SPS    = 16,
    parameter int DATA_W = 12
) (
    input logic                 clk,
    input logic                 rst,
    bpsk_symbol_mapper_if.slave bus
);
    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state_q;
    state_t            state_d;

    logic [7:0]        fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_d;
    logic              fifo_empty;
    logic              push;
    logic [7:0]        pop_byte;

    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic [2:0]        nxt_idx;
    logic [CNT_W-1:0]  smp_cnt;

    logic              accept;
    logic              bit_end;
    logic              byte_end;
    logic              pop;
    logic              go_idle;
    logic              load_bit;
    logic              new_data;
    logic              tx_bit;

    logic              bit_out_q;
    logic [DATA_W-1:0] mod_out_q;
    logic              mod_valid_q;
    logic              data_rdy_q;
    logic [DATA_W-1:0] sine_neg;

`ifdef DBPSK_DIFF_EN
    logic              diff_ref;
`endif

    assign fifo_empty     = (count == 2'd0);
    assign bus.byte_ready = (count < 2'd2);
    assign push           = bus.byte_valid & bus.byte_ready;
    assign pop_byte       = fifo_mem[rd_ptr];
    assign nxt_idx        = bit_idx - 3'd1;

    // Negation with saturation so the most negative sample never wraps.
    assign sine_neg = (bus.sine_in == MIN_NEG) ? MAX_POS : -bus.sine_in;

    assign bus.bit_out   = bit_out_q;
    assign bus.mod_out   = mod_out_q;
    assign bus.mod_valid = mod_valid_q;
    assign bus.data_rdy  = data_rdy_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = SEND;
            SEND:    if (go_idle)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: sample acceptance, bit/byte boundaries and FIFO pop.
    always_comb begin
        accept   = 1'b0;
        bit_end  = 1'b0;
        byte_end = 1'b0;
        pop      = 1'b0;
        go_idle  = 1'b0;
        case (state_q)
            IDLE: begin
                pop = !fifo_empty;
            end
            SEND: begin
                accept   = bus.mod_en & bus.sample_strobe;
                bit_end  = accept & (smp_cnt == CNT_LAST);
                byte_end = bit_end & (bit_idx == 3'd0);
                pop      = byte_end & !fifo_empty;
                go_idle  = byte_end & fifo_empty;
            end
            default: ;
        endcase
    end

    // FIFO occupancy after this cycle's push and pop.
    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + 2'd1;
        end else if (!push && pop) begin
            count_d = count - 2'd1;
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.byte_in;
        end
    end

    // Data bit that starts on this edge: MSB of a freshly popped byte, or the
    // next lower bit of the shift register.
    always_comb begin
        if (pop) begin
            new_data = pop_byte[7];
        end else begin
            new_data = shreg[nxt_idx];
        end
        load_bit = pop | (bit_end & !byte_end);
`ifdef DBPSK_DIFF_EN
        tx_bit = new_data ^ diff_ref;
`else
        tx_bit = new_data;
`endif
    end

`ifdef DBPSK_DIFF_EN
    // Differential reference: last transmitted symbol bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_ref <= 1'b0;
        end else if (load_bit) begin
            diff_ref <= tx_bit;
        end
    end
`endif

    // Shift register, bit index, sample counter and symbol bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= 8'd0;
            bit_idx   <= 3'd0;
            smp_cnt   <= '0;
            bit_out_q <= 1'b0;
        end else begin
            if (pop) begin
                shreg   <= pop_byte;
                bit_idx <= 3'd7;
                smp_cnt <= '0;
            end else if (bit_end) begin
                bit_idx <= nxt_idx;
                smp_cnt <= '0;
            end else if (accept) begin
                smp_cnt <= smp_cnt + CNT_W'(1);
            end

            if (load_bit) begin
                bit_out_q <= tx_bit;
            end else if (go_idle) begin
                bit_out_q <= 1'b0;
            end
        end
    end

    // Modulated sample register; forced to zero once no bit is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mod_out_q   <= '0;
            mod_valid_q <= 1'b0;
        end else begin
            mod_valid_q <= accept;
            if (accept) begin
                mod_out_q <= bit_out_q ? bus.sine_in : sine_neg;
            end else if (state_q == IDLE) begin
                mod_out_q <= '0;
            end
        end
    end

    // Controller request: a bit is in flight or a byte is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rdy_q <= 1'b0;
        end else begin
            data_rdy_q <= (state_d == SEND) || (count_d != 2'd0);
        end
    end

endmodule

// File: tb/tb_bpsk_symbol_mapper.sv
// Bench for bpsk_symbol_mapper: directed scenarios plus randomized traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_bpsk_symbol_mapper;
    localparam int SPS    = 4;
    localparam int DATA_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpsk_symbol_mapper_if #(.DATA_W(DATA_W)) bus ();

    bpsk_symbol_mapper #(.SPS(SPS), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0] m_fifo [$];
    bit         m_bits [$];
    int         m_cnt   = 0;
    bit         m_send  = 0;
    bit         m_ref   = 0;
    bit         m_init  = 0;
    bit         m_pushed = 0;
    int         e_mod   = 0;
    bit         e_valid = 0;
    bit         e_bit   = 0;
    bit         e_rdy   = 0;

    // Observation bookkeeping.
    int cyc = 0;
    int n_valid = 0;
    int first_v = -1;
    int last_v  = -1;
    bit sgn_q [$];

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no event expected event (cycle %0d)", tag, cyc);
    endtask

    function automatic int neg_sat(input int s);
        if (s == -(1 << (DATA_W - 1))) return (1 << (DATA_W - 1)) - 1;
        return -s;
    endfunction

    task automatic load_byte();
        logic [7:0] b;
        bit d;
        b = m_fifo.pop_front();
        for (int i = 7; i >= 0; i--) begin
            d = b[i];
`ifdef DBPSK_DIFF_EN
            d = d ^ m_ref;
            m_ref = d;
`endif
            m_bits.push_back(d);
        end
        m_cnt  = 0;
        m_send = 1;
        e_bit  = m_bits[0];
    endtask

    task automatic clear_obs();
        n_valid = 0;
        first_v = -1;
        last_v  = -1;
        sgn_q.delete();
    endtask

    // One clock: advance the model with the applied inputs, then compare.
    task automatic step();
        bit en, stb, vld, was_send, push;
        int sine;
        logic [7:0] bi;
        if (m_init && !rst) check_eq("byte_ready", bus.byte_ready, (m_fifo.size() < 2));
        en   = bus.mod_en;
        stb  = bus.sample_strobe;
        vld  = bus.byte_valid;
        bi   = bus.byte_in;
        sine = int'($signed(bus.sine_in));
        @(posedge clk);
        if (rst) begin
            m_fifo.delete();
            m_bits.delete();
            m_cnt = 0; m_send = 0; m_ref = 0; m_pushed = 0;
            e_mod = 0; e_valid = 0; e_bit = 0;
            m_init = 1;
        end else begin
            push = vld && (m_fifo.size() < 2);
            was_send = m_send;
            if (was_send && en && stb) begin
                e_mod = m_bits[0] ? sine : neg_sat(sine);
                e_valid = 1;
                m_cnt++;
                if (m_cnt == SPS) begin
                    m_cnt = 0;
                    m_bits.delete(0);
                    if (m_bits.size() == 0) begin
                        if (m_fifo.size() > 0) load_byte();
                        else begin
                            m_send = 0;
                            e_bit  = 0;
                        end
                    end else begin
                        e_bit = m_bits[0];
                    end
                end
            end else begin
                e_valid = 0;
                if (!was_send) e_mod = 0;
            end
            if (!was_send && m_fifo.size() > 0) load_byte();
            if (push) m_fifo.push_back(bi);
            m_pushed = push;
        end
        e_rdy = m_send || (m_fifo.size() > 0);
        #1;
        cyc++;
        check_eq("mod_valid", bus.mod_valid, e_valid);
        check_eq("mod_out", $signed(bus.mod_out), e_mod);
        check_eq("bit_out", bus.bit_out, e_bit);
        check_eq("data_rdy", bus.data_rdy, e_rdy);
        if (bus.mod_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            n_valid++;
            sgn_q.push_back($signed(bus.mod_out) > 0);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        step();
        while (!m_pushed && stalls < 1000) begin
            stalls++;
            step();
        end
        if (!m_pushed) fail_timeout("push_accept");
        bus.byte_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (!m_send && m_fifo.size() == 0) return;
        end
        fail_timeout("drain");
    endtask

    initial begin
        int st, guard;
        logic [7:0] pat;

        bus.byte_in = 8'd0;
        bus.byte_valid = 1'b0;
        bus.mod_en = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.sine_in = '0;

        // Reset state.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_byte_ready", bus.byte_ready, 1);
        check_eq("rst_mod_out", $signed(bus.mod_out), 0);
        step();

        // 0xA5 with constant carrier: sign pattern follows the bits.
        bus.mod_en = 1'b1;
        bus.sample_strobe = 1'b1;
        bus.sine_in = DATA_W'(100);
        clear_obs();
        push_byte(8'hA5, st);
        run_until_idle(200);
        check_eq("a5_samples", n_valid, 8 * SPS);
        check_eq("a5_data_rdy_low", bus.data_rdy, 0);
        step();
        check_eq("a5_mod_out_zero", $signed(bus.mod_out), 0);
        pat = 8'hA5;
        if (sgn_q.size() == 8 * SPS) begin
            for (int k = 0; k < 8 * SPS; k++)
                check_eq("a5_sign", sgn_q[k], pat[7 - k / SPS]);
        end

        // Back-to-back bytes: gapless stream, fourth push stalls.
        clear_obs();
        push_byte(8'hFF, st);
        push_byte(8'h00, st);
        push_byte(8'h81, st);
        push_byte(8'h55, st);
        check_eq("fourth_push_stalled", (st > 0), 1);
        run_until_idle(400);
        check_eq("b2b_samples", n_valid, 32 * SPS);
        check_eq("b2b_gapless", last_v - first_v + 1, 32 * SPS);

        // Most negative sample on a 0 bit saturates.
        clear_obs();
        bus.sine_in = {1'b1, {(DATA_W-1){1'b0}}};
        push_byte(8'h00, st);
        guard = 0;
        while (n_valid == 0 && guard < 50) begin
            step();
            guard++;
        end
        if (n_valid == 0) fail_timeout("sat_valid");
        check_eq("sat_mod_out", $signed(bus.mod_out), 2047);
        run_until_idle(200);

        // mod_en dropped mid-bit: no samples, bit still gets SPS samples.
        clear_obs();
        bus.sine_in = DATA_W'(300);
        push_byte(8'hC3, st);
        guard = 0;
        while (n_valid < 2 && guard < 50) begin
            step();
            guard++;
        end
        bus.mod_en = 1'b0;
        st = n_valid;
        for (int i = 0; i < 10; i++) step();
        check_eq("en_low_no_valid", n_valid - st, 0);
        bus.mod_en = 1'b1;
        run_until_idle(200);
        check_eq("en_gap_samples", n_valid, 8 * SPS);

        // Reset in the middle of bit 3 with a second byte buffered.
        clear_obs();
        push_byte(8'h5A, st);
        push_byte(8'h3C, st);
        guard = 0;
        while (n_valid < 3 * SPS + 2 && guard < 200) begin
            step();
            guard++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_mod_out", $signed(bus.mod_out), 0);
        check_eq("midrst_mod_valid", bus.mod_valid, 0);
        check_eq("midrst_bit_out", bus.bit_out, 0);
        check_eq("midrst_data_rdy", bus.data_rdy, 0);
        check_eq("midrst_byte_ready", bus.byte_ready, 1);
        clear_obs();
        for (int i = 0; i < 6; i++) step();
        check_eq("midrst_no_resume", n_valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.mod_en        = ($urandom_range(0, 9) < 8);
            bus.sample_strobe = ($urandom_range(0, 9) < 7);
            bus.byte_valid    = ($urandom_range(0, 9) < 3);
            bus.byte_in       = 8'($urandom);
            if ($urandom_range(0, 9) == 0) bus.sine_in = {1'b1, {(DATA_W-1){1'b0}}};
            else bus.sine_in = DATA_W'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        bus.byte_valid = 1'b0;
        bus.mod_en = 1'b1;
        bus.sample_strobe = 1'b1;
        run_until_idle(500);
        step();
        check_eq("final_data_rdy", bus.data_rdy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
